// File: rtl/rtsnoc_pkg.sv
// -----------------------------------------------------------------------------
// rtsnoc_pkg
// Shared definitions for RTSNoC local-port endpoints.
//   - header field widths and NOC_BUS_SIZE derivation
//   - data-transform mode encodings
//   - FSM state encodings for the echo endpoint
//   - field-position helpers that every endpoint uses to pack and unpack
//     the bus.
//     Bus layout, MSB to LSB:
//       X_orig, Y_orig, local_orig[2:0], X_dst, Y_dst, local_dst[2:0], data
// -----------------------------------------------------------------------------
package rtsnoc_pkg;

  localparam int LOCAL_ADDR_W = 3;

  typedef enum logic [1:0] {
    MODE_ECHO = 2'd0,
    MODE_INC  = 2'd1,
    MODE_INV  = 2'd2,
    MODE_SINK = 2'd3
  } mode_e;

  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_WAIT  = 2'd1,
    TX_WRITE = 2'd2
  } tx_state_e;

  // Total bus width: payload plus two (X,Y,local) address triples.
  function automatic int noc_bus_size(input int sx, input int sy, input int dw);
    return dw + 2 * sx + 2 * sy + 2 * LOCAL_ADDR_W;
  endfunction

  // LSB of local_dst.
  function automatic int noc_dst_local_lsb(input int dw);
    return dw;
  endfunction

  // LSB of the {X_dst, Y_dst} pair.
  function automatic int noc_dst_xy_lsb(input int dw);
    return dw + LOCAL_ADDR_W;
  endfunction

  // LSB of local_orig; {X_orig, Y_orig, local_orig} is contiguous from here.
  function automatic int noc_orig_local_lsb(input int sx, input int sy, input int dw);
    return dw + LOCAL_ADDR_W + sx + sy;
  endfunction

endpackage

// File: rtl/rtsnoc_echo_fifo_if.sv
// -----------------------------------------------------------------------------
// rtsnoc_echo_fifo_if
// Router local-port bundle.
//   dout/nd   : packet offered by the router, nd = packet valid
//   rd        : one-cycle pop strobe from the endpoint
//   din/wr    : packet and one-cycle write strobe from the endpoint
//   wait_req  : router cannot accept a write
// The master modport is the router side; the slave modport is the endpoint.
// -----------------------------------------------------------------------------
interface rtsnoc_echo_fifo_if #(
  parameter int BUS_W = rtsnoc_pkg::noc_bus_size(1, 1, 16)
);
  logic [BUS_W-1:0] dout;
  logic             nd;
  logic             rd;
  logic [BUS_W-1:0] din;
  logic             wr;
  logic             wait_req;

  modport master (output dout, nd, wait_req, input rd, din, wr);
  modport slave  (input dout, nd, wait_req, output rd, din, wr);
endinterface

// File: rtl/rtsnoc_sync_fifo.sv
// -----------------------------------------------------------------------------
// rtsnoc_sync_fifo
// Single-clock FIFO of 2^DEPTH_LOG2 entries.
//   clk_i, rst_n_i : clock, async active-low reset (empties the FIFO)
//   push_i/wdata_i : write request and data (ignored when full)
//   pop_i/rdata_o  : read request and head of queue (ignored when empty)
//   full_o/empty_o : derived from the registered level only
//   level_o        : registered occupancy 0..2^DEPTH_LOG2
// -----------------------------------------------------------------------------
module rtsnoc_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  push_s;
  logic                  pop_s;

  assign full_o  = (level_q == LEVEL_FULL);
  assign empty_o = (level_q == {(DEPTH_LOG2+1){1'b0}});
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks net change.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= {DEPTH_LOG2{1'b0}};
      rd_ptr_q <= {DEPTH_LOG2{1'b0}};
      level_q  <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   level_q <= level_q + LEVEL_ONE;
        2'b01:   level_q <= level_q - LEVEL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/rtsnoc_echo_fifo.sv
// -----------------------------------------------------------------------------
// rtsnoc_echo_fifo
// Buffered echo endpoint for an RTSNoC router local port. Accepted packets get
// origin/destination swapped, an optional data transform, and are queued for
// re-injection towards their sender.
//   clk_i, rst_n_i : clock, async active-low reset
//   noc_if         : router local port (slave side)
//   mode_i         : 0 echo, 1 data+1, 2 ~data, 3 sink (drop everything)
//   rx/tx/drop_count_o : wrapping packet counters
//   fifo_level_o   : current FIFO occupancy
// -----------------------------------------------------------------------------
module rtsnoc_echo_fifo
  import rtsnoc_pkg::*;
#(
  parameter int          SOC_SIZE_X      = 1,
  parameter int          SOC_SIZE_Y      = 1,
  parameter int          NOC_DATA_WIDTH  = 16,
  parameter logic [2:0]  RX_ADDR         = 3'd0,
  parameter logic [2:0]  TX_ADDR         = 3'd0,
  parameter int          FIFO_DEPTH_LOG2 = 2,
  parameter int          CNT_WIDTH       = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  rtsnoc_echo_fifo_if.slave          noc_if,
  input  logic [1:0]                 mode_i,
  output logic [CNT_WIDTH-1:0]       rx_count_o,
  output logic [CNT_WIDTH-1:0]       tx_count_o,
  output logic [CNT_WIDTH-1:0]       drop_count_o,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level_o
);
  localparam int NOC_BUS_SIZE = noc_bus_size(SOC_SIZE_X, SOC_SIZE_Y, NOC_DATA_WIDTH);
  localparam int XY_W         = SOC_SIZE_X + SOC_SIZE_Y;
  localparam int DST_LOC_LSB  = noc_dst_local_lsb(NOC_DATA_WIDTH);
  localparam int DST_XY_LSB   = noc_dst_xy_lsb(NOC_DATA_WIDTH);
  localparam int ORIG_LOC_LSB = noc_orig_local_lsb(SOC_SIZE_X, SOC_SIZE_Y, NOC_DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NOC_DATA_WIDTH-1:0] DATA_ONE = {{(NOC_DATA_WIDTH-1){1'b0}}, 1'b1};

  // Swap the address triples, stamp our origin address, transform the payload.
  function automatic logic [NOC_BUS_SIZE-1:0] build_reply(
    input logic [NOC_BUS_SIZE-1:0] rx,
    input mode_e                   mode
  );
    logic [NOC_DATA_WIDTH-1:0] data;
    case (mode)
      MODE_INC: data = rx[NOC_DATA_WIDTH-1:0] + DATA_ONE;
      MODE_INV: data = ~rx[NOC_DATA_WIDTH-1:0];
      default:  data = rx[NOC_DATA_WIDTH-1:0];
    endcase
    // {X_dst,Y_dst} become the new origin; {X_orig,Y_orig,local_orig} the new destination.
    return {rx[DST_XY_LSB +: XY_W], TX_ADDR, rx[ORIG_LOC_LSB +: XY_W + LOCAL_ADDR_W], data};
  endfunction

  rx_state_e rx_state_q, rx_state_d;
  tx_state_e tx_state_q, tx_state_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [NOC_BUS_SIZE-1:0] din_q, din_d;
  logic [CNT_WIDTH-1:0]    rx_cnt_q, tx_cnt_q, drop_cnt_q;

  mode_e                   mode_s;
  logic                    accept_s;
  logic                    push_s, pop_s;
  logic                    rx_inc_s, tx_inc_s, drop_inc_s;
  logic                    full_s, empty_s;
  logic [NOC_BUS_SIZE-1:0] head_s;

  assign mode_s   = mode_e'(mode_i);
  assign accept_s = (noc_if.dout[DST_LOC_LSB +: LOCAL_ADDR_W] == RX_ADDR) && (mode_s != MODE_SINK);

  rtsnoc_sync_fifo #(
    .WIDTH      (NOC_BUS_SIZE),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push_s),
    .wdata_i (build_reply(noc_if.dout, mode_s)),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .level_o (fifo_level_o)
  );

  // RX next-state: pop the router when not full; the packet is queued or dropped on the same edge.
  always_comb begin
    rx_state_d = rx_state_q;
    rd_d       = 1'b0;
    push_s     = 1'b0;
    rx_inc_s   = 1'b0;
    drop_inc_s = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (noc_if.nd && !full_s) begin
          rd_d       = 1'b1;
          rx_state_d = RX_ACK;
          rx_inc_s   = 1'b1;
          if (accept_s) begin
            push_s = 1'b1;
          end else begin
            drop_inc_s = 1'b1;
          end
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_ACK:  rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // TX next-state: load head into din, wait for the router, strobe wr for one cycle.
  always_comb begin
    tx_state_d = tx_state_q;
    wr_d       = 1'b0;
    pop_s      = 1'b0;
    tx_inc_s   = 1'b0;
    din_d      = din_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (!empty_s) begin
          din_d      = head_s;
          pop_s      = 1'b1;
          tx_state_d = TX_WAIT;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_WAIT: begin
        if (!noc_if.wait_req) begin
          wr_d       = 1'b1;
          tx_state_d = TX_WRITE;
        end else begin
          tx_state_d = TX_WAIT;
        end
      end
      TX_WRITE: begin
        tx_inc_s   = 1'b1;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // FSM state and registered router-facing outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_state_q <= RX_IDLE;
      tx_state_q <= TX_IDLE;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      din_q      <= {NOC_BUS_SIZE{1'b0}};
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      din_q      <= din_d;
    end
  end

  // Traffic counters, wrapping silently.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_cnt_q   <= {CNT_WIDTH{1'b0}};
      tx_cnt_q   <= {CNT_WIDTH{1'b0}};
      drop_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      if (rx_inc_s)   rx_cnt_q   <= rx_cnt_q + CNT_ONE;
      if (tx_inc_s)   tx_cnt_q   <= tx_cnt_q + CNT_ONE;
      if (drop_inc_s) drop_cnt_q <= drop_cnt_q + CNT_ONE;
    end
  end

  assign noc_if.rd    = rd_q;
  assign noc_if.wr    = wr_q;
  assign noc_if.din   = din_q;
  assign rx_count_o   = rx_cnt_q;
  assign tx_count_o   = tx_cnt_q;
  assign drop_count_o = drop_cnt_q;
endmodule

// File: tb/tb_rtsnoc_echo_fifo.sv
`timescale 1ns/1ps
module tb_rtsnoc_echo_fifo;
  localparam int BW = 26;
  localparam logic [2:0] RXA = 3'd2;
  localparam logic [2:0] TXA = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] rx_cnt, tx_cnt, drop_cnt;
  logic [2:0]  level;

  rtsnoc_echo_fifo_if #(.BUS_W(BW)) noc_if();

  rtsnoc_echo_fifo #(
    .SOC_SIZE_X(1), .SOC_SIZE_Y(1), .NOC_DATA_WIDTH(16),
    .RX_ADDR(RXA), .TX_ADDR(TXA), .FIFO_DEPTH_LOG2(2), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .noc_if(noc_if), .mode_i(mode),
    .rx_count_o(rx_cnt), .tx_count_o(tx_cnt), .drop_count_o(drop_cnt),
    .fifo_level_o(level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int model_rx = 0, model_drop = 0, model_push = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] offer_q[$];
  logic [BW-1:0] obs_mem[256];
  int obs_wr = 0, obs_rd = 0;
  int rd_pulses = 0, cyc = 0, last_rd_cyc = 0, last_wr_cyc = 0;
  bit rand_wait_en = 1'b0;

  always @(posedge clk) cyc++;

  // Router-side monitor: capture every write and count pop strobes.
  always @(negedge clk) begin
    if (rst_n && noc_if.wr === 1'b1) begin
      obs_mem[obs_wr & 255] = noc_if.din;
      obs_wr++;
      last_wr_cyc = cyc;
    end
    if (rst_n && noc_if.rd === 1'b1) begin
      rd_pulses++;
      last_rd_cyc = cyc;
    end
  end

  function automatic logic [BW-1:0] mk(input int xo, input int yo, input int lo,
                                       input int xd, input int yd, input int ld,
                                       input logic [15:0] d);
    logic [BW-1:0] r;
    r = '0;
    r[25] = xo[0]; r[24] = yo[0]; r[23:21] = lo[2:0];
    r[20] = xd[0]; r[19] = yd[0]; r[18:16] = ld[2:0];
    r[15:0] = d;
    return r;
  endfunction

  // Expected reply: the sender becomes the destination, we become the origin.
  function automatic logic [BW-1:0] ref_reply(input logic [BW-1:0] p, input int m);
    int d;
    d = int'(p[15:0]);
    if (m == 1) d = (d + 1) % 65536;
    else if (m == 2) d = 65535 - d;
    return mk(int'(p[20]), int'(p[19]), int'(TXA), int'(p[25]), int'(p[24]),
              int'(p[23:21]), d[15:0]);
  endfunction

  // Offer queued packets like a router; account each accepted packet in the model.
  task automatic drive_offers(input int max_cycles, output int n_taken);
    logic [BW-1:0] p;
    n_taken = 0;
    for (int c = 0; c < max_cycles && offer_q.size() > 0; c++) begin
      p = offer_q[0];
      noc_if.dout = p;
      noc_if.nd = 1'b1;
      if (rand_wait_en) noc_if.wait_req = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (noc_if.rd === 1'b1) begin
        void'(offer_q.pop_front());
        n_taken++;
        model_rx++;
        if (p[18:16] == RXA && mode != 2'd3) begin
          exp_q.push_back(ref_reply(p, int'(mode)));
          model_push++;
        end else begin
          model_drop++;
        end
      end
    end
    noc_if.nd = 1'b0;
  endtask

  task automatic wait_out(input int n, input int max_cycles, input string tag);
    int c;
    c = 0;
    while ((obs_wr - obs_rd) < n && c < max_cycles) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if ((obs_wr - obs_rd) < n) begin
      $display("FAIL %s_timeout: got %0d writes, want %0d", tag, obs_wr - obs_rd, n);
      n_bad++;
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({noc_if.rd, noc_if.wr, noc_if.din, rx_cnt, tx_cnt, drop_cnt, level} !== '0) begin
      $display("FAIL reset_initial: rd=%b wr=%b din=%h rx=%0d tx=%0d drop=%0d lvl=%0d want all 0",
               noc_if.rd, noc_if.wr, noc_if.din, rx_cnt, tx_cnt, drop_cnt, level);
      n_bad++;
    end
    noc_if.nd = 1'b1;
    noc_if.dout = mk(1, 1, 1, 0, 0, int'(RXA), 16'hAAAA);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({noc_if.rd, rx_cnt, level} !== '0) begin
      $display("FAIL reset_held: rd=%b rx=%0d lvl=%0d want 0", noc_if.rd, rx_cnt, level);
      n_bad++;
    end
    noc_if.nd = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_echo();
    int t, base;
    logic [BW-1:0] got;
    base = rd_pulses;
    mode = 2'd0;
    noc_if.wait_req = 1'b0;
    offer_q.push_back(mk(1, 0, 5, 0, 1, int'(RXA), 16'h1234));
    drive_offers(10, t);
    wait_out(1, 20, "echo");
    repeat (3) @(negedge clk);
    got = obs_mem[obs_rd & 255];
    obs_rd++;
    n_cmp++;
    if (got !== mk(0, 1, int'(TXA), 1, 0, 5, 16'h1234)) begin
      $display("FAIL echo_din: got %h want %h", got, mk(0, 1, int'(TXA), 1, 0, 5, 16'h1234));
      n_bad++;
    end
    void'(exp_q.pop_front());
    n_cmp++;
    if (rd_pulses - base != 1) begin
      $display("FAIL echo_rd_pulses: got %0d want 1", rd_pulses - base);
      n_bad++;
    end
    n_cmp++;
    if (last_wr_cyc - last_rd_cyc != 2) begin
      $display("FAIL echo_latency: wr edge - rd edge = %0d want 2", last_wr_cyc - last_rd_cyc);
      n_bad++;
    end
    n_cmp++;
    if (rx_cnt !== 16'd1 || tx_cnt !== 16'd1) begin
      $display("FAIL echo_counts: rx=%0d tx=%0d want 1/1", rx_cnt, tx_cnt);
      n_bad++;
    end
  endtask

  task automatic test_transforms();
    int t;
    logic [BW-1:0] got, want;
    mode = 2'd1;
    offer_q.push_back(mk(0, 1, 3, 1, 1, int'(RXA), 16'hFFFF));
    drive_offers(10, t);
    mode = 2'd2;
    offer_q.push_back(mk(1, 1, 7, 0, 0, int'(RXA), 16'h00F0));
    drive_offers(10, t);
    mode = 2'd0;
    wait_out(2, 30, "xform");
    for (int i = 0; i < 2; i++) begin
      got = obs_mem[obs_rd & 255];
      obs_rd++;
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        $display("FAIL xform_pkt%0d: got %h want %h", i, got, want);
        n_bad++;
      end
      n_cmp++;
      if (got[15:0] !== ((i == 0) ? 16'h0000 : 16'hFF0F)) begin
        $display("FAIL xform_data%0d: got %h want %h", i, got[15:0], (i == 0) ? 16'h0000 : 16'hFF0F);
        n_bad++;
      end
    end
  endtask

  task automatic test_filter_sink();
    int t, base;
    base = rd_pulses;
    mode = 2'd0;
    offer_q.push_back(mk(1, 0, 1, 1, 0, int'(RXA ^ 3'd1), 16'h5555));
    drive_offers(10, t);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (drop_cnt !== 16'd1 || obs_wr != obs_rd || rd_pulses - base != 1) begin
      $display("FAIL filter: drop=%0d writes=%0d rd=%0d want 1/0/1", drop_cnt, obs_wr - obs_rd, rd_pulses - base);
      n_bad++;
    end
    mode = 2'd3;
    offer_q.push_back(mk(0, 0, 2, 1, 1, int'(RXA), 16'h6666));
    drive_offers(10, t);
    mode = 2'd0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (drop_cnt !== 16'd2 || obs_wr != obs_rd || rd_pulses - base != 2) begin
      $display("FAIL sink: drop=%0d writes=%0d rd=%0d want 2/0/2", drop_cnt, obs_wr - obs_rd, rd_pulses - base);
      n_bad++;
    end
    n_cmp++;
    if (drop_cnt !== 16'(model_drop)) begin
      $display("FAIL drop_model: got %0d want %0d", drop_cnt, model_drop);
      n_bad++;
    end
  endtask

  task automatic test_backpressure();
    int t, base;
    logic [BW-1:0] got, want;
    base = rd_pulses;
    mode = 2'd0;
    noc_if.wait_req = 1'b1;
    for (int i = 0; i < 6; i++)
      offer_q.push_back(mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                           $urandom_range(0, 1), $urandom_range(0, 1), int'(RXA), 16'($urandom)));
    drive_offers(40, t);
    n_cmp++;
    if (t != 5 || rd_pulses - base != 5) begin
      $display("FAIL bp_taken: taken=%0d rd=%0d want 5/5", t, rd_pulses - base);
      n_bad++;
    end
    n_cmp++;
    if (level !== 3'd4) begin
      $display("FAIL bp_level: got %0d want 4", level);
      n_bad++;
    end
    n_cmp++;
    if (obs_wr != obs_rd) begin
      $display("FAIL bp_no_write: got %0d writes want 0", obs_wr - obs_rd);
      n_bad++;
    end
    noc_if.wait_req = 1'b0;
    drive_offers(40, t);
    wait_out(6, 100, "bp");
    repeat (4) @(negedge clk);
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got = (obs_rd < obs_wr) ? obs_mem[obs_rd & 255] : 'x;
      obs_rd++;
      n_cmp++;
      if (got !== want) begin
        $display("FAIL bp_order: got %h want %h", got, want);
        n_bad++;
      end
    end
    n_cmp++;
    if (level !== 3'd0 || tx_cnt !== 16'(model_push)) begin
      $display("FAIL bp_drain: lvl=%0d tx=%0d want 0/%0d", level, tx_cnt, model_push);
      n_bad++;
    end
  endtask

  task automatic test_random();
    int t;
    logic [BW-1:0] got, want;
    rand_wait_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      mode = 2'($urandom_range(0, 3));
      offer_q.push_back(mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                           $urandom_range(0, 1), $urandom_range(0, 1),
                           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : int'(RXA),
                           16'($urandom)));
      drive_offers(60, t);
      n_cmp++;
      if (t != 1) begin
        $display("FAIL rand_accept%0d: taken=%0d want 1", i, t);
        n_bad++;
        offer_q.delete();
      end
    end
    rand_wait_en = 1'b0;
    noc_if.wait_req = 1'b0;
    mode = 2'd0;
    wait_out(exp_q.size(), 200, "rand");
    repeat (4) @(negedge clk);
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got = (obs_rd < obs_wr) ? obs_mem[obs_rd & 255] : 'x;
      obs_rd++;
      n_cmp++;
      if (got !== want) begin
        $display("FAIL rand_pkt: got %h want %h", got, want);
        n_bad++;
      end
    end
    n_cmp++;
    if (rx_cnt !== 16'(model_rx) || tx_cnt !== 16'(model_push) || drop_cnt !== 16'(model_drop)) begin
      $display("FAIL rand_counts: rx=%0d tx=%0d drop=%0d want %0d/%0d/%0d",
               rx_cnt, tx_cnt, drop_cnt, model_rx, model_push, model_drop);
      n_bad++;
    end
  endtask

  task automatic test_reset_midop();
    int t;
    logic [BW-1:0] got, want;
    mode = 2'd0;
    noc_if.wait_req = 1'b1;
    for (int i = 0; i < 4; i++)
      offer_q.push_back(mk(1, 1, i, 0, 0, int'(RXA), 16'(16'h0100 + i)));
    drive_offers(30, t);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (level !== 3'd3 || t != 4) begin
      $display("FAIL midrst_pre: lvl=%0d taken=%0d want 3/4", level, t);
      n_bad++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({noc_if.rd, noc_if.wr, noc_if.din, rx_cnt, tx_cnt, drop_cnt, level} !== '0) begin
      $display("FAIL midrst_async: rd=%b wr=%b din=%h rx=%0d tx=%0d drop=%0d lvl=%0d want all 0",
               noc_if.rd, noc_if.wr, noc_if.din, rx_cnt, tx_cnt, drop_cnt, level);
      n_bad++;
    end
    exp_q.delete();
    model_rx = 0; model_drop = 0; model_push = 0;
    noc_if.wait_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    obs_rd = obs_wr;
    @(negedge clk);
    offer_q.push_back(mk(0, 1, 4, 1, 0, int'(RXA), 16'hBEEF));
    drive_offers(10, t);
    wait_out(1, 20, "midrst");
    repeat (3) @(negedge clk);
    want = exp_q.pop_front();
    got = obs_mem[obs_rd & 255];
    obs_rd++;
    n_cmp++;
    if (got !== want) begin
      $display("FAIL midrst_echo: got %h want %h", got, want);
      n_bad++;
    end
    n_cmp++;
    if (rx_cnt !== 16'd1 || tx_cnt !== 16'd1 || obs_wr != obs_rd) begin
      $display("FAIL midrst_counts: rx=%0d tx=%0d extra=%0d want 1/1/0", rx_cnt, tx_cnt, obs_wr - obs_rd);
      n_bad++;
    end
  endtask

  initial begin
    noc_if.dout = '0;
    noc_if.nd = 1'b0;
    noc_if.wait_req = 1'b0;
    test_reset();
    test_single_echo();
    test_transforms();
    test_filter_sink();
    test_backpressure();
    test_random();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
